pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central pipeline stall controller and multi-cycle mul/div sequencer for the 5-stage MIPS core.
- Merges the ID load-use stall request with the EX mul/div busy condition into the shared stall bus, which PC/IF/ID/EX/MEM/WB consume.
- Drives the start, cancel and done handshake of the iterative mul/div unit.
- Keeps a stall-cycle performance counter.

Parameters:
STALL_W, 6, stall bus width: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
MD_TIMEOUT, 64, max BUSY cycles before forced completion.
CNT_W, 32, stall_cycles counter width.

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
stallreq_id  in  1  load-use hazard from ID (level)
ex_md_req  in  1  EX holds an unfinished mul/div instruction (level)
ex_md_op  in  2  00 mult, 01 multu, 10 div, 11 divu
md_ready  in  1  mul/div unit result valid (1-cycle pulse)
flush  in  1  cancel in-flight mul/div
stall  out  STALL_W  stall bus
md_start  out  1  start pulse to mul/div unit
md_op  out  2  op latched at start
md_cancel  out  1  abort pulse to mul/div unit
md_busy  out  1  state==BUSY
md_done  out  1  EX selects mul/div result this cycle
md_err  out  1  sticky timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with stall[0]=1

Behaviour:
- Reset values: state IDLE; md_op=00; md_err=0; timeout counter 0; stall_cycles=0.
  - stall=000000 while rst is high.
  - md_start, md_cancel, md_done, md_busy = 0.
  - Reset mid-BUSY: return to IDLE with no md_cancel pulse, because the unit shares the reset.
- FSM states IDLE, BUSY, DONE; registered state.
- IDLE:
  - ex_md_req=1 and flush=0: md_start=1 (combinational, 1 cycle); latch md_op<=ex_md_op; counter<=0; next BUSY.
  - md_ready in IDLE is ignored.
- BUSY:
  - Counter increments each cycle.
  - md_ready=1: next DONE.
  - Otherwise, counter==MD_TIMEOUT-1: set md_err; next DONE (deadlock escape).
  - flush=1 takes priority over both: md_cancel=1 for 1 cycle; next IDLE.
- DONE: md_done=1 for exactly one cycle; next IDLE unconditionally.
  - Back-to-back mul/div: ex_md_req is high again in IDLE the following cycle, so a new md_start is issued.
- EX stall condition: ex_stall = ex_md_req & (state!=DONE) & ~flush.
  - ex_stall therefore covers the IDLE start cycle and all BUSY cycles.
  - It is released in DONE so EX advances with the result.
- Stall bus (combinational, priority EX over ID):
  - ex_stall=1: 001111.
  - Else stallreq_id=1: 000111.
  - Else 000000.
  - MEM and WB are never stopped.
- Simultaneous stallreq_id and ex_stall: 001111 (superset). ID's request persists and is honoured once EX releases.
- stall_cycles: +1 on each clock where stall[0]=1; saturates at all-ones; cleared only by rst.
- md_err cleared only by rst.
- flush in IDLE or DONE: no cancel pulse; state transitions unchanged.

Decomposition:
- Shared defines header:
  - STALL_W.
  - Stop/NoStop.
  - Stall bus patterns STALL_NONE=000000, STALL_ID=000111, STALL_EX=001111.
  - md_op encodings.
  - FSM state encodings.
- One natural sub-module: sat_counter (parameterised width, inc enable, synchronous clear, saturate), used for stall_cycles.
- The timeout counter is kept inline.

Test Plan:
- Load-use only: stallreq_id=1 for 1 cycle, ex_md_req=0 -> stall=000111 that cycle, 000000 next; stall_cycles=1.
- Divide, unit ready after 33 cycles: ex_md_req=1, ex_md_op=10 -> md_start pulse cycle 0, md_op=10, stall=001111 cycles 0..33, md_done and stall=000000 at cycle 34, state IDLE at cycle 35.
- Simultaneous: ex_md_req=1 and stallreq_id=1 -> stall=001111 while BUSY; in DONE with stallreq_id still 1 -> stall=000111.
- Timeout: md_ready never asserted, MD_TIMEOUT=64 -> md_err=1 after 64 BUSY cycles, md_done next cycle, md_err stays 1 until rst.
- Flush mid-BUSY at cycle 5 -> md_cancel pulse that cycle, stall=000000, IDLE next; a late md_ready causes no md_done.
- Reset mid-BUSY plus counter saturation (CNT_W=4, 20 stall cycles): stall_cycles holds 15; rst -> all outputs at reset values next cycle, stall_cycles=0.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller.
// Contents: the stall bus width and bit meaning, the Stop/NoStop levels, the
// canonical stall bus patterns, the mul/div op encodings, the mul/div sequencer
// FSM state encodings, and a helper that maps stall causes onto a bus pattern.
// Stall bus bit order: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
package pipe_stall_ctrl_pkg;

  localparam int STALL_BUS_W = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [STALL_BUS_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_BUS_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_BUS_W-1:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  // EX stall wins over ID: stopping EX also freezes everything upstream of it,
  // which already contains the ID request. MEM and WB keep draining.
  function automatic logic [STALL_BUS_W-1:0] stall_pattern(input logic ex_stall,
                                                           input logic id_stall);
    logic [STALL_BUS_W-1:0] pat;
    if (ex_stall == STOP) begin
      pat = STALL_EX;
    end else if (id_stall == STOP) begin
      pat = STALL_ID;
    end else begin
      pat = STALL_NONE;
    end
    return pat;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter (sat_counter).
// Ports:
//   clk   - clock
//   clr   - synchronous clear (highest priority)
//   inc   - count enable; the count holds once it reaches all-ones
//   count - current count value
module pipe_stall_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count register: clear, saturating increment, or hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller and iterative mul/div sequencer.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   stallreq_id   - load-use hazard request from ID (level)
//   ex_md_req     - EX holds an unfinished mul/div instruction (level)
//   ex_md_op      - mul/div operation presented by EX
//   md_ready      - mul/div unit result valid (1-cycle pulse)
//   flush         - cancel any in-flight mul/div
//   stall         - stall bus to PC/IF/ID/EX/MEM/WB (1 = stop)
//   md_start      - start pulse to the mul/div unit
//   md_op         - operation latched at start
//   md_cancel     - abort pulse to the mul/div unit
//   md_busy       - sequencer is waiting on the unit
//   md_done       - EX takes the mul/div result this cycle
//   md_err        - sticky flag: the unit never answered and was timed out
//   stall_cycles  - saturating count of cycles in which the PC was stopped
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int STALL_W    = STALL_BUS_W,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               ex_md_req,
  input  logic [1:0]         ex_md_op,
  input  logic               md_ready,
  input  logic               flush,
  output logic [STALL_W-1:0] stall,
  output logic               md_start,
  output logic [1:0]         md_op,
  output logic               md_cancel,
  output logic               md_busy,
  output logic               md_done,
  output logic               md_err,
  output logic [CNT_W-1:0]   stall_cycles
);

  localparam int TO_W = $clog2(MD_TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

  md_state_e    state_r;
  md_state_e    state_nxt_s;
  md_op_e       md_op_r;
  logic         md_err_r;
  logic [TO_W-1:0] to_cnt_r;

  logic         md_start_s;
  logic         md_cancel_s;
  logic         timeout_s;
  logic         ex_stall_s;
  logic [STALL_W-1:0] stall_s;

  // Sequencer state, latched op, timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      md_op_r  <= MD_MULT;
      md_err_r <= 1'b0;
      to_cnt_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (md_start_s) begin
        md_op_r  <= md_op_e'(ex_md_op);
        to_cnt_r <= '0;
      end else if (state_r == ST_BUSY) begin
        md_op_r  <= md_op_r;
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end else begin
        md_op_r  <= md_op_r;
        to_cnt_r <= to_cnt_r;
      end
      if (timeout_s) begin
        md_err_r <= 1'b1;
      end else begin
        md_err_r <= md_err_r;
      end
    end
  end

  // Next-state and handshake pulses. While rst is high nothing is driven:
  // the mul/div unit shares the reset, so no cancel is needed either.
  always_comb begin
    state_nxt_s = state_r;
    md_start_s  = 1'b0;
    md_cancel_s = 1'b0;
    timeout_s   = 1'b0;
    if (rst) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // md_ready is deliberately ignored here (stale or late pulse).
          if (ex_md_req && !flush) begin
            md_start_s  = 1'b1;
            state_nxt_s = ST_BUSY;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (flush) begin
            md_cancel_s = 1'b1;
            state_nxt_s = ST_IDLE;
          end else if (md_ready) begin
            state_nxt_s = ST_DONE;
          end else if (to_cnt_r == TO_LAST) begin
            // Unit never answered: force completion so the pipe cannot deadlock.
            timeout_s   = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_BUSY;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Stall bus: EX is held from the start cycle through BUSY and released in
  // DONE so it advances with the result; a flush drops the EX hold at once.
  always_comb begin
    ex_stall_s = ex_md_req && (state_r != ST_DONE) && !flush;
    if (rst) begin
      stall_s = STALL_W'(STALL_NONE);
    end else begin
      stall_s = STALL_W'(stall_pattern(ex_stall_s, stallreq_id));
    end
  end

  pipe_stall_ctrl_sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_s[0]),
    .count (stall_cycles)
  );

  assign stall     = stall_s;
  assign md_start  = md_start_s;
  assign md_cancel = md_cancel_s;
  assign md_busy   = !rst && (state_r == ST_BUSY);
  assign md_done   = !rst && (state_r == ST_DONE);
  assign md_op     = md_op_r;
  assign md_err    = md_err_r;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (CNT_W=4 so counter saturation is reachable).
module tb_pipe_stall_ctrl;

  logic       clk;
  logic       rst;
  logic       stallreq_id;
  logic       ex_md_req;
  logic [1:0] ex_md_op;
  logic       md_ready;
  logic       flush;
  logic [5:0] stall;
  logic       md_start;
  logic [1:0] md_op;
  logic       md_cancel;
  logic       md_busy;
  logic       md_done;
  logic       md_err;
  logic [3:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0] stall;
    logic       start;
    logic       cancel;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] op;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  // Reference state for the registered outputs.
  logic [3:0] exp_cnt = 4'd0;
  logic       exp_err = 1'b0;
  logic [1:0] exp_op  = 2'b00;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_ID   = 6'b000111;
  localparam logic [5:0] S_EX   = 6'b001111;

  pipe_stall_ctrl #(
    .STALL_W    (6),
    .MD_TIMEOUT (64),
    .CNT_W      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .ex_md_req    (ex_md_req),
    .ex_md_op     (ex_md_op),
    .md_ready     (md_ready),
    .flush        (flush),
    .stall        (stall),
    .md_start     (md_start),
    .md_op        (md_op),
    .md_cancel    (md_cancel),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .md_err       (md_err),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input string name,
                     input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed %h expected %h", tag, name, obs, exp);
    end
  endtask

  // One clock: queue the expectation, compare at the falling edge, advance
  // the reference state, then return 1 time unit after the next rising edge.
  task automatic step(input string tag, input logic [5:0] e_stall,
                      input logic e_start, input logic e_cancel,
                      input logic e_busy, input logic e_done);
    exp_t e;
    exp_t got;
    e.stall  = e_stall;
    e.start  = e_start;
    e.cancel = e_cancel;
    e.busy   = e_busy;
    e.done   = e_done;
    e.err    = exp_err;
    e.op     = exp_op;
    e.cnt    = exp_cnt;
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    chk(tag, "stall",        {2'b00, stall},        {2'b00, got.stall});
    chk(tag, "md_start",     {7'd0, md_start},      {7'd0, got.start});
    chk(tag, "md_cancel",    {7'd0, md_cancel},     {7'd0, got.cancel});
    chk(tag, "md_busy",      {7'd0, md_busy},       {7'd0, got.busy});
    chk(tag, "md_done",      {7'd0, md_done},       {7'd0, got.done});
    chk(tag, "md_err",       {7'd0, md_err},        {7'd0, got.err});
    chk(tag, "md_op",        {6'd0, md_op},         {6'd0, got.op});
    chk(tag, "stall_cycles", {4'd0, stall_cycles},  {4'd0, got.cnt});
    if (rst) begin
      exp_cnt = 4'd0;
      exp_err = 1'b0;
      exp_op  = 2'b00;
    end else begin
      if (e_start) exp_op = ex_md_op;
      if (e_stall[0] && (exp_cnt != 4'hF)) exp_cnt = exp_cnt + 4'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; ex_md_req = 1'b0; ex_md_op = 2'b00;
    md_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset: requests present but every output must stay quiet.
    stallreq_id = 1'b1; ex_md_req = 1'b1;
    step("reset", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use only, one cycle.
    rst = 1'b0; ex_md_req = 1'b0; stallreq_id = 1'b1;
    step("loaduse", S_ID, 1'b0, 1'b0, 1'b0, 1'b0);
    stallreq_id = 1'b0;
    step("loaduse_rel", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    // Stray md_ready in IDLE is ignored.
    md_ready = 1'b1;
    step("idle_ready", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    md_ready = 1'b0;
    step("idle_ready2", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);

    // Divide with unit ready in the 33rd BUSY cycle.
    ex_md_req = 1'b1; ex_md_op = 2'b10;
    step("div_start", S_EX, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 33; i++) begin
      md_ready = (i == 33);
      step("div_busy", S_EX, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    md_ready = 1'b0;
    step("div_done", S_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    ex_md_req = 1'b0;
    step("div_idle", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);

    // Simultaneous ID and EX requests, then back-to-back start.
    ex_md_req = 1'b1; stallreq_id = 1'b1; ex_md_op = 2'b00;
    step("sim_start", S_EX, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      md_ready = (i == 3);
      step("sim_busy", S_EX, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    md_ready = 1'b0;
    step("sim_done", S_ID, 1'b0, 1'b0, 1'b0, 1'b1);
    stallreq_id = 1'b0; ex_md_op = 2'b11;
    step("b2b_start", S_EX, 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush in the 5th cycle after start, then a late md_ready.
    for (int i = 1; i <= 4; i++) begin
      step("fl_busy", S_EX, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    flush = 1'b1;
    step("fl_cancel", S_NONE, 1'b0, 1'b1, 1'b1, 1'b0);
    flush = 1'b0; ex_md_req = 1'b0; md_ready = 1'b1;
    step("fl_late_rdy", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    md_ready = 1'b0;
    step("fl_idle", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flush in IDLE: request suppressed, no cancel pulse.
    ex_md_req = 1'b1; flush = 1'b1;
    step("fl_in_idle", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    ex_md_req = 1'b0; flush = 1'b0;
    step("fl_in_idle2", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout: unit never answers.
    ex_md_req = 1'b1; ex_md_op = 2'b01;
    step("to_start", S_EX, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      step("to_busy", S_EX, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    exp_err = 1'b1;
    step("to_done", S_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    ex_md_req = 1'b0;
    step("to_sticky", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    step("to_sticky2", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-BUSY with the stall counter saturated.
    ex_md_req = 1'b1; ex_md_op = 2'b10;
    step("rb_start", S_EX, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step("rb_busy", S_EX, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    rst = 1'b1;
    step("rb_reset", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; ex_md_req = 1'b0;
    step("rb_after", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    ex_md_req = 1'b1; ex_md_op = 2'b11;
    step("rb_restart", S_EX, 1'b1, 1'b0, 1'b0, 1'b0);
    ex_md_req = 1'b0;
    step("rb_busy_again", S_NONE, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
